// File: rtl/cmd_fifo_pkg.sv
// cmd_fifo_pkg: shared sizing helpers and operation encoding for cmd_fifo.
// Imported by cmd_fifo and wrap_counter so that the pointer and level widths
// have a single definition.
package cmd_fifo_pkg;
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  typedef struct packed {
    logic push;
    logic pop;
  } fifo_op_t;
endpackage

// File: rtl/cmd_fifo_wrap_counter.sv
// wrap_counter: modulo-MAX pointer for cmd_fifo; counts 0..MAX-1 and wraps.
// Ports: clk, rst (async active-low), inc (advance by one), clear (to zero,
// wins over inc), value (current count).
module wrap_counter import cmd_fifo_pkg::*; #(
  parameter int MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  clear,
  output logic [ptr_w(MAX)-1:0] value
);
  localparam int W = ptr_w(MAX);
  always_ff @(posedge clk or negedge rst)
    if (!rst) value <= '0;
    else if (clear) value <= '0;
    else if (inc) value <= value == W'(MAX - 1) ? '0 : value + W'(1);
endmodule

// File: rtl/cmd_fifo.sv
// cmd_fifo: DEPTH-slot circular command FIFO with ready/valid style handshake.
// Ports: clk, rst (async active-low); push side i, i_isReady, i_canReceive;
// pop side o, o_hasAny, o_consume; flush (sync discard); level (occupancy).
// Option: define CMD_FIFO_BYPASS_EN to pass i straight to o while empty.
module cmd_fifo import cmd_fifo_pkg::*; #(
  parameter int CMD_SIZE = 1,
  parameter int DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CMD_SIZE-1:0]     i,
  input  logic                    i_isReady,
  output logic                    i_canReceive,
  output logic [CMD_SIZE-1:0]     o,
  output logic                    o_hasAny,
  input  logic                    o_consume,
  input  logic                    flush,
  output logic [lvl_w(DEPTH)-1:0] level
);
  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  logic [CMD_SIZE-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic stored, byp;
  fifo_op_t op;
  assign stored = level != '0;
`ifdef CMD_FIFO_BYPASS_EN
  assign byp = ~stored & ~flush;
`else
  assign byp = 1'b0;
`endif
  assign i_canReceive = ~flush & (level != LW'(DEPTH) | o_consume);
  assign o_hasAny     = byp ? i_isReady : stored;
  assign o            = byp ? i : mem[rd_ptr];
  // A bypassed command consumed in the same cycle never touches storage.
  assign op.push = i_isReady & i_canReceive & ~(byp & o_consume);
  assign op.pop  = o_consume & o_hasAny & ~byp;
  always_ff @(posedge clk or negedge rst)
    if (!rst) level <= '0;
    else if (flush) level <= '0;
    else if (op.push != op.pop) level <= op.push ? level + LW'(1) : level - LW'(1);
  always_ff @(posedge clk)
    if (op.push) mem[wr_ptr] <= i;
  wrap_counter #(.MAX(DEPTH)) u_wr (
    .clk(clk), .rst(rst), .inc(op.push), .clear(flush), .value(wr_ptr)
  );
  wrap_counter #(.MAX(DEPTH)) u_rd (
    .clk(clk), .rst(rst), .inc(op.pop), .clear(flush), .value(rd_ptr)
  );
endmodule

// File: doc/cmd_fifo.md
CMD_FIFO -- requirements
Module: cmd_fifo

Interface
REQ-001 SHALL have parameter CMD_SIZE, default 1: command width in bits, >=1.
REQ-002 SHALL have parameter DEPTH, default 4: number of storage slots, >=2, not required to be a power of two.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i  input  CMD_SIZE  command to push.
REQ-006 SHALL have port i_isReady  input  1  push request, legal only while i_canReceive is high.
REQ-007 SHALL have port i_canReceive  output  1  FIFO can accept a push this cycle.
REQ-008 SHALL have port o  output  CMD_SIZE  oldest command, meaningful only while o_hasAny is high.
REQ-009 SHALL have port o_hasAny  output  1  at least one command is available.
REQ-010 SHALL have port o_consume  input  1  pop request, legal only while o_hasAny is high.
REQ-011 SHALL have port flush  input  1  synchronous discard of all contents.
REQ-012 SHALL have port level  output  $clog2(DEPTH+1)  number of stored commands.

Function
REQ-013 SHALL store commands in a DEPTH-slot circular array with read and write pointers; stored data SHALL NOT shift between slots.
REQ-014 SHALL advance each pointer by one per accepted operation and wrap from DEPTH-1 to 0.
REQ-015 SHALL drive i_canReceive = ~flush & (level != DEPTH | o_consume), so a push is accepted into a full FIFO when a pop occurs in the same cycle.
REQ-016 SHALL drive o_hasAny = level != 0, with o taken from the slot at the read pointer.
REQ-017 SHALL accept a push when i_isReady & i_canReceive, and a pop when o_consume & o_hasAny.
REQ-018 SHALL update level by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-019 SHALL give flush priority over push and pop: level, read pointer and write pointer are 0 on the next cycle, and slot contents are don't-care.
REQ-020 SHALL deliver commands in strict FIFO order with no loss or duplication.
REQ-021 SHALL make a command pushed into a FIFO with level 0 visible on o one cycle after the push, unless CMD_FIFO_BYPASS_EN applies.
REQ-022 SHALL leave state unchanged on an illegal pop (o_consume while o_hasAny is low) or an illegal push (i_isReady while i_canReceive is low).

Reset
REQ-023 SHALL on rst low immediately set level=0, both pointers=0, o_hasAny=0 and i_canReceive=1 (i_canReceive also depends on flush), independent of clk.
REQ-024 SHALL treat a reset that occurs mid-operation as discarding all contents, with no partial commands retained.
REQ-025 SHALL NOT reset slot data.

Configuration
REQ-026 SHALL honour macro CMD_FIFO_BYPASS_EN, described in REQ-027 and REQ-028.
REQ-027 With CMD_FIFO_BYPASS_EN defined, while level is 0 and no flush, the FIFO SHALL drive o=i and o_hasAny=i_isReady combinationally.
- A same-cycle o_consume SHALL consume that command without storing it or changing level.
- Without o_consume, the command SHALL be stored normally.
REQ-028 With CMD_FIFO_BYPASS_EN undefined, o and o_hasAny SHALL depend only on registered state (latency 1).

Structure
REQ-029 SHALL take the pointer-width and level-width helper constants from the shared library package and SHALL NOT redefine them locally.
REQ-030 SHALL implement each pointer as an instance of sub-module wrap_counter.
- Parameter: MAX.
- Ports: inc, clear, value.
- Behaviour: wraps at MAX-1; clear has priority over inc.

Verification
REQ-031 Bench SHALL push 4 commands 0x1..0x4 with DEPTH=4 -> level=4, i_canReceive=0, then pops return 0x1,0x2,0x3,0x4 in order.
REQ-032 Bench SHALL hold the FIFO full (DEPTH=4) and push 0x5 with a pop in the same cycle -> push accepted, level stays 4, next o=0x2.
REQ-033 Bench SHALL use DEPTH=3, performing 10 push/pop pairs of 0x0..0x9 -> outputs 0x0..0x9 in order across pointer wrap, and level never exceeds 1.
REQ-034 Bench SHALL assert flush with level=2 together with a push of 0xA -> next cycle level=0, o_hasAny=0, and 0xA is dropped.
REQ-035 Bench SHALL drive rst low mid-stream with level=3 -> level=0 and o_hasAny=0 before the next clk edge, and the FIFO accepts pushes after rst goes high.
REQ-036 Bench SHALL, with CMD_FIFO_BYPASS_EN defined and the FIFO empty, push 0x7 with o_consume high -> o=0x7 in the same cycle and level remains 0; without the macro, o_hasAny rises one cycle later.
